sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter NPORTS, default 3, SHALL set the number of requester ports (legal 2..4).
REQ-002 clk  in  1  SHALL be the single clock; all logic SHALL be rising-edge.
REQ-003 reset_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 p_req  in  NPORTS  SHALL be the per-port request, held until that port's ack.
REQ-005 p_we  in  NPORTS  SHALL select the access type per port: 1=write, 0=read.
REQ-006 p_addr  in  NPORTS*20  SHALL carry the flattened word addresses, port i at [20i+19:20i].
REQ-007 p_wdata  in  NPORTS*16  SHALL carry the flattened write data.
REQ-008 p_ack  out  NPORTS  SHALL give a one-cycle completion pulse per port.
REQ-009 p_rdata  out  16  SHALL carry read data, valid while the reading port's p_ack is high.
REQ-010 m_read_req, m_write_req  out  1 each  SHALL be the request outputs to the SDRAM controller.
REQ-011 m_r_addr, m_w_addr  out  20 each; m_din  out  16  SHALL carry the latched access fields.
REQ-012 m_read_gnt, m_write_gnt, m_read_valid  in  1 each; m_dout  in  16  SHALL be the controller responses.
REQ-013 arb_state  out  2  SHALL expose the current FSM state for debug.

Function
REQ-014 The FSM SHALL have four states:
- IDLE=0
- REQ=1
- WAIT_RD=2
- WAIT_GNT_LOW=3
REQ-015 In IDLE with any eligible p_req, the arbiter SHALL pick a winner, latch its id, p_we, p_addr and p_wdata, and enter REQ on the next edge.
REQ-016 A port SHALL be ineligible in any cycle where its own p_ack is high.
REQ-017 Round-robin: the search SHALL start at last_grant+1 modulo NPORTS; last_grant SHALL reset to NPORTS-1, so port 0 wins first.
REQ-018 In REQ, exactly one of m_read_req/m_write_req SHALL be high, per the latched we.
REQ-019 m_r_addr and m_w_addr SHALL both carry the latched address, and m_din the latched wdata.
REQ-020 In REQ, on m_write_gnt=1 with we=1, the arbiter SHALL on the next edge:
- drop m_write_req;
- pulse p_ack[winner];
- update last_grant;
- enter WAIT_GNT_LOW.
REQ-021 In REQ, on m_read_gnt=1 with we=0, the arbiter SHALL drop m_read_req, update last_grant and enter WAIT_RD.
REQ-022 In WAIT_RD, on the first cycle of m_read_valid=1, the arbiter SHALL on the next edge:
- register m_dout into p_rdata;
- pulse p_ack[winner];
- enter WAIT_GNT_LOW.
REQ-023 WAIT_GNT_LOW SHALL return to IDLE in the first cycle where both m_read_gnt and m_write_gnt are 0.
REQ-024 The arbiter SHALL never assert m_read_req and m_write_req together.
REQ-025 At most one request SHALL be outstanding; a new request SHALL not be issued before return to IDLE.
REQ-026 Grant inputs seen in a state other than REQ SHALL be ignored; m_read_valid outside WAIT_RD SHALL be ignored.
REQ-027 p_req changes after selection SHALL not affect the access in flight.
REQ-028 Worst-case wait for any requesting port SHALL be NPORTS-1 other accesses (round-robin mode).

Reset
REQ-029 On reset_n=0 at a clock edge, the arbiter SHALL set:
- state=IDLE;
- m_read_req=0 and m_write_req=0;
- p_ack=0;
- p_rdata=0;
- last_grant=NPORTS-1;
- latched fields=0.
REQ-030 Reset asserted mid-access SHALL abandon the access without an ack; the controller is reset in the same cycle.

Configuration
REQ-031 With SDRAM_ARB_FIXED_PRIO_EN defined, port 0 SHALL win whenever eligible, and ports 1..NPORTS-1 SHALL round-robin among themselves.
REQ-032 Without SDRAM_ARB_FIXED_PRIO_EN, pure round-robin over all ports SHALL apply.

Structure
REQ-033 Package sdram_arb_pkg SHALL hold the FSM state encoding, the address width (20) and the data width (16).
REQ-034 The winner search SHALL live in sub-module sdram_rr_picker: inputs req vector and last_grant; outputs winner id and a valid flag; combinational.

Verification
REQ-035 Single write: port 1 writes addr 0x12345, data 0xBEEF -> m_write_req with m_w_addr=0x12345 and m_din=0xBEEF; p_ack[1] exactly one cycle after m_write_gnt rises.
REQ-036 Single read: port 2 reads 0x00010; model returns 0xA5A5 -> p_rdata=0xA5A5 with a p_ack[2] pulse; exactly one ack per request.
REQ-037 Contention: ports 0, 1 and 2 request continuously -> grant order 0,1,2,0,1,2; no port is starved.
REQ-038 Fixed-priority build: ports 0 and 2 both requesting continuously -> port 0 always wins, port 2 waits; after port 0 idles, port 2 wins.
REQ-039 Long grant: write_gnt held high 4 cycles -> single ack, no reissue until gnt low.
REQ-040 Reset in WAIT_RD -> all outputs return to reset values; read_valid after reset produces no ack.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding and field widths.
package sdram_arb_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int ID_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_REQ          = 2'd1,
        ST_WAIT_RD      = 2'd2,
        ST_WAIT_GNT_LOW = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational winner search starting one past last_grant.
// With SDRAM_ARB_FIXED_PRIO_EN defined, port 0 overrides and ports 1.. round-robin.
module sdram_rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 3
) (
    input  logic [NPORTS-1:0] req,
    input  logic [ID_W-1:0]   last_grant,
    output logic [ID_W-1:0]   winner,
    output logic              valid
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NPORTS;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            if (req[idx] && idx != 0) begin
`else
            if (req[idx]) begin
`endif
                winner = idx[ID_W-1:0];
                valid  = 1'b1;
            end
        end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            winner = '0;
            valid  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port front end for a single SDRAM controller; one access in flight at a time.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NPORTS-1:0]        p_req,
    input  logic [NPORTS-1:0]        p_we,
    input  logic [NPORTS*ADDR_W-1:0] p_addr,
    input  logic [NPORTS*DATA_W-1:0] p_wdata,
    output logic [NPORTS-1:0]        p_ack,
    output logic [DATA_W-1:0]        p_rdata,
    output logic                     m_read_req,
    output logic                     m_write_req,
    output logic [ADDR_W-1:0]        m_r_addr,
    output logic [ADDR_W-1:0]        m_w_addr,
    output logic [DATA_W-1:0]        m_din,
    input  logic                     m_read_gnt,
    input  logic                     m_write_gnt,
    input  logic                     m_read_valid,
    input  logic [DATA_W-1:0]        m_dout,
    output logic [1:0]               arb_state
);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   winner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [NPORTS-1:0] eligible;
    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic              do_latch;
    logic              do_grant;
    logic              do_ack;
    logic              do_rdata;

    // A port whose ack is high this cycle is still holding a stale request.
    assign eligible = p_req & ~p_ack;

    sdram_rr_picker #(.NPORTS(NPORTS)) u_picker (
        .req        (eligible),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        do_latch = 1'b0;
        do_grant = 1'b0;
        do_ack   = 1'b0;
        do_rdata = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    do_latch = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (we_q && m_write_gnt) begin
                    do_grant = 1'b1;
                    do_ack   = 1'b1;
                    state_d  = ST_WAIT_GNT_LOW;
                end else if (!we_q && m_read_gnt) begin
                    do_grant = 1'b1;
                    state_d  = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (m_read_valid) begin
                    do_rdata = 1'b1;
                    do_ack   = 1'b1;
                    state_d  = ST_WAIT_GNT_LOW;
                end
            end
            ST_WAIT_GNT_LOW: begin
                if (!m_read_gnt && !m_write_gnt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NPORTS - 1);
            winner_q     <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            p_ack        <= '0;
            p_rdata      <= '0;
        end else begin
            state_q <= state_d;
            p_ack   <= '0;
            if (do_latch) begin
                winner_q <= pick_id;
                we_q     <= p_we[pick_id];
                addr_q   <= p_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                wdata_q  <= p_wdata[int'(pick_id)*DATA_W +: DATA_W];
            end
            if (do_grant) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                // Port 0 wins outside the rotation, so it never moves the pointer.
                if (winner_q != '0) begin
                    last_grant_q <= winner_q;
                end
`else
                last_grant_q <= winner_q;
`endif
            end
            if (do_ack) begin
                p_ack[winner_q] <= 1'b1;
            end
            if (do_rdata) begin
                p_rdata <= m_dout;
            end
        end
    end

    assign m_read_req  = (state_q == ST_REQ) && !we_q;
    assign m_write_req = (state_q == ST_REQ) && we_q;
    assign m_r_addr    = addr_q;
    assign m_w_addr    = addr_q;
    assign m_din       = wdata_q;
    assign arb_state   = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (NPORTS=3); controller responses are driven by hand.
module tb_sdram_port_arbiter;

    localparam int NP = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NP-1:0]   p_req;
    logic [NP-1:0]   p_we;
    logic [NP*20-1:0] p_addr;
    logic [NP*16-1:0] p_wdata;
    logic [NP-1:0]   p_ack;
    logic [15:0]     p_rdata;
    logic            m_read_req, m_write_req;
    logic [19:0]     m_r_addr, m_w_addr;
    logic [15:0]     m_din;
    logic            m_read_gnt, m_write_gnt, m_read_valid;
    logic [15:0]     m_dout;
    logic [1:0]      arb_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NPORTS(NP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .p_req        (p_req),
        .p_we         (p_we),
        .p_addr       (p_addr),
        .p_wdata      (p_wdata),
        .p_ack        (p_ack),
        .p_rdata      (p_rdata),
        .m_read_req   (m_read_req),
        .m_write_req  (m_write_req),
        .m_r_addr     (m_r_addr),
        .m_w_addr     (m_w_addr),
        .m_din        (m_din),
        .m_read_gnt   (m_read_gnt),
        .m_write_gnt  (m_write_gnt),
        .m_read_valid (m_read_valid),
        .m_dout       (m_dout),
        .arb_state    (arb_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 32'(arb_state), 32'd0);
        check({tag, "_rreq"}, 32'(m_read_req), 32'd0);
        check({tag, "_wreq"}, 32'(m_write_req), 32'd0);
        check({tag, "_ack"}, 32'(p_ack), 32'd0);
    endtask

    initial begin
        int exp_port;
        reset_n      = 1'b0;
        p_req        = '0;
        p_we         = '0;
        p_addr       = '0;
        p_wdata      = '0;
        m_read_gnt   = 1'b0;
        m_write_gnt  = 1'b0;
        m_read_valid = 1'b0;
        m_dout       = '0;
        step();
        step();

        // Reset state
        check_idle_outputs("rst");
        check("rst_rdata", 32'(p_rdata), 32'd0);
        check("rst_raddr", 32'(m_r_addr), 32'd0);
        check("rst_din", 32'(m_din), 32'd0);
        reset_n = 1'b1;
        step();
        check("rst_stay_idle", 32'(arb_state), 32'd0);

        // Single write from port 1
        p_req[1] = 1'b1;
        p_we[1]  = 1'b1;
        p_addr[20 +: 20]  = 20'h12345;
        p_wdata[16 +: 16] = 16'hBEEF;
        step();
        check("wr_state_req", 32'(arb_state), 32'd1);
        check("wr_wreq", 32'(m_write_req), 32'd1);
        check("wr_rreq", 32'(m_read_req), 32'd0);
        check("wr_waddr", 32'(m_w_addr), 32'h12345);
        check("wr_raddr", 32'(m_r_addr), 32'h12345);
        check("wr_din", 32'(m_din), 32'hBEEF);
        step();
        check("wr_hold_req", 32'(m_write_req), 32'd1);
        check("wr_no_early_ack", 32'(p_ack), 32'd0);
        m_write_gnt = 1'b1;
        step();
        check("wr_ack", 32'(p_ack), 32'b010);
        check("wr_wreq_drop", 32'(m_write_req), 32'd0);
        check("wr_state_wgl", 32'(arb_state), 32'd3);
        p_req[1] = 1'b0;
        step();
        check("wr_ack_one_cycle", 32'(p_ack), 32'd0);
        check("wr_wait_gnt_low", 32'(arb_state), 32'd3);
        m_write_gnt = 1'b0;
        step();
        check_idle_outputs("wr_done");

        // Single read from port 2
        p_req[2] = 1'b1;
        p_we[2]  = 1'b0;
        p_addr[40 +: 20] = 20'h00010;
        step();
        check("rd_state_req", 32'(arb_state), 32'd1);
        check("rd_rreq", 32'(m_read_req), 32'd1);
        check("rd_wreq", 32'(m_write_req), 32'd0);
        check("rd_raddr", 32'(m_r_addr), 32'h00010);
        m_read_gnt = 1'b1;
        step();
        check("rd_state_wait", 32'(arb_state), 32'd2);
        check("rd_rreq_drop", 32'(m_read_req), 32'd0);
        check("rd_no_ack_at_gnt", 32'(p_ack), 32'd0);
        m_read_gnt   = 1'b0;
        m_dout       = 16'hA5A5;
        m_read_valid = 1'b1;
        step();
        check("rd_ack", 32'(p_ack), 32'b100);
        check("rd_data", 32'(p_rdata), 32'hA5A5);
        p_req[2] = 1'b0;
        m_dout   = 16'h0F0F;
        step();
        check("rd_single_ack", 32'(p_ack), 32'd0);
        check("rd_data_hold", 32'(p_rdata), 32'hA5A5);
        m_read_valid = 1'b0;
        check_idle_outputs("rd_done");

        // Contention: all three ports write continuously; last grant was port 2
        p_we  = 3'b111;
        p_req = 3'b111;
        for (int i = 0; i < NP; i++) begin
            p_addr[i*20 +: 20]  = 20'h00100 + 20'(i);
            p_wdata[i*16 +: 16] = 16'h1000 + 16'(i);
        end
        for (int n = 0; n < 6; n++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = n % NP;
`endif
            step();
            check("ct_wreq", 32'(m_write_req), 32'd1);
            check("ct_addr", 32'(m_w_addr), 32'h100 + 32'(exp_port));
            check("ct_din", 32'(m_din), 32'h1000 + 32'(exp_port));
            m_write_gnt = 1'b1;
            step();
            check("ct_ack", 32'(p_ack), 32'd1 << exp_port);
            m_write_gnt = 1'b0;
            step();
            check("ct_idle", 32'(arb_state), 32'd0);
        end
        p_req = '0;
        step();

        // Long grant: write_gnt high for 4 cycles while port 1 keeps requesting
        p_req = 3'b010;
        step();
        check("lg_wreq", 32'(m_write_req), 32'd1);
        check("lg_addr", 32'(m_w_addr), 32'h101);
        m_write_gnt = 1'b1;
        step();
        check("lg_ack", 32'(p_ack), 32'b010);
        for (int c = 0; c < 3; c++) begin
            step();
            check("lg_no_ack", 32'(p_ack), 32'd0);
            check("lg_no_reissue", 32'(m_write_req), 32'd0);
            check("lg_wgl", 32'(arb_state), 32'd3);
        end
        p_req = '0;
        m_write_gnt = 1'b0;
        step();
        check_idle_outputs("lg_done");

        // Reset while waiting for read data
        p_req[0] = 1'b1;
        p_we[0]  = 1'b0;
        p_addr[0 +: 20] = 20'h55555;
        step();
        check("rr_rreq", 32'(m_read_req), 32'd1);
        check("rr_raddr", 32'(m_r_addr), 32'h55555);
        m_read_gnt = 1'b1;
        step();
        check("rr_wait_rd", 32'(arb_state), 32'd2);
        m_read_gnt = 1'b0;
        p_req   = '0;
        reset_n = 1'b0;
        step();
        check_idle_outputs("rr_reset");
        check("rr_rdata", 32'(p_rdata), 32'd0);
        check("rr_addr", 32'(m_r_addr), 32'd0);
        check("rr_din", 32'(m_din), 32'd0);
        reset_n      = 1'b1;
        m_dout       = 16'h1234;
        m_read_valid = 1'b1;
        step();
        step();
        check("rr_valid_ignored_ack", 32'(p_ack), 32'd0);
        check("rr_valid_ignored_data", 32'(p_rdata), 32'd0);
        check("rr_valid_ignored_state", 32'(arb_state), 32'd0);
        m_read_valid = 1'b0;

        // last_grant restored to NPORTS-1: port 0 beats port 1
        p_we  = 3'b011;
        p_req = 3'b011;
        step();
        check("rr_first_winner", 32'(m_w_addr), 32'h55555);
        m_write_gnt = 1'b1;
        step();
        check("rr_first_ack", 32'(p_ack), 32'b001);
        p_req = '0;
        m_write_gnt = 1'b0;
        step();
        check("rr_first_idle", 32'(arb_state), 32'd0);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
        // Fixed priority: port 0 always beats port 2 until it stops requesting
        p_we  = 3'b111;
        p_req = 3'b101;
        p_addr[0 +: 20]  = 20'h0AAAA;
        p_addr[40 +: 20] = 20'h0CCCC;
        for (int n = 0; n < 3; n++) begin
            step();
            check("fp_p0_wins", 32'(m_w_addr), 32'h0AAAA);
            m_write_gnt = 1'b1;
            step();
            check("fp_p0_ack", 32'(p_ack), 32'b001);
            m_write_gnt = 1'b0;
            step();
        end
        p_req = 3'b100;
        step();
        check("fp_p2_wins", 32'(m_w_addr), 32'h0CCCC);
        m_write_gnt = 1'b1;
        step();
        check("fp_p2_ack", 32'(p_ack), 32'b100);
        p_req = '0;
        m_write_gnt = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
